// File: rtl/wb_port_arb.sv
// Write Back register-file port arbiter: shares one write port between the
// in-order pipeline and a 2-entry FIFO of long-latency results, with a pending scoreboard.
module wb_port_arb #(
  parameter int AGE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [2:0]  pipe_reg,
  input  logic [15:0] pipe_data,
  output logic        pipe_stall,
  input  logic        issue_valid,
  input  logic [2:0]  issue_reg,
  input  logic        lu_valid,
  input  logic [2:0]  lu_reg,
  input  logic [15:0] lu_data,
  output logic        lu_ready,
  output logic [7:0]  pend_busy,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_reg,
  output logic [15:0] rf_wr_data
);

  localparam int AW = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [2:0]    fifo_reg  [2];
  logic [15:0]   fifo_data [2];
  logic [1:0]    count;
  logic [AW-1:0] age;

  logic       fifo_gnt;
  logic       push;
  logic       wr_idx;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  assign lu_ready   = (count != 2'd2);
  assign push       = lu_valid && lu_ready;
  assign fifo_gnt   = (count != 2'd0) &&
                      (!pipe_valid || (count == 2'd2) || (age >= AGE_LIM));
  assign pipe_stall = pipe_valid && fifo_gnt;
  // A push lands behind whatever entry survives this cycle's pop.
  assign wr_idx     = (count == 2'd1) && !fifo_gnt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    rf_wr_en   = 1'b0;
    rf_wr_reg  = '0;
    rf_wr_data = '0;
    set_mask   = '0;
    clr_mask   = '0;
    if (fifo_gnt) begin
      rf_wr_en   = 1'b1;
      rf_wr_reg  = fifo_reg[0];
      rf_wr_data = fifo_data[0];
      clr_mask   = 8'b1 << fifo_reg[0];
    end else if (pipe_valid) begin
      rf_wr_en   = 1'b1;
      rf_wr_reg  = pipe_reg;
      rf_wr_data = pipe_data;
    end
    if (issue_valid) set_mask = 8'b1 << issue_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      age       <= '0;
      pend_busy <= '0;
      // NOTE: the two-entry buffer is small enough to clear on reset, so no stale result survives.
      for (int i = 0; i < 2; i++) begin
        fifo_reg[i]  <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      count     <= count + 2'(push) - 2'(fifo_gnt);
      pend_busy <= (pend_busy & ~clr_mask) | set_mask;

      if ((count == 2'd0) || fifo_gnt) begin
        age <= '0;
      end else if (age != AGE_LIM) begin
        age <= age + 1'b1;
      end

      if (fifo_gnt) begin
        fifo_reg[0]  <= fifo_reg[1];
        fifo_data[0] <= fifo_data[1];
      end
      if (push) begin
        fifo_reg[wr_idx]  <= lu_reg;
        fifo_data[wr_idx] <= lu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Scoreboard bench for wb_port_arb: a queue-based reference model predicts each
// cycle's port outputs; a negedge monitor pops and compares them.
module tb_wb_port_arb;

  localparam int AGE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [2:0]  pipe_reg = '0;
  logic [15:0] pipe_data = '0;
  logic        pipe_stall;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_reg = '0;
  logic        lu_valid = 1'b0;
  logic [2:0]  lu_reg = '0;
  logic [15:0] lu_data = '0;
  logic        lu_ready;
  logic [7:0]  pend_busy;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;

  wb_port_arb #(.AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .pend_busy(pend_busy),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] r; logic [15:0] d; } ent_t;
  typedef struct {
    logic en; logic [2:0] r; logic [15:0] d;
    logic stall; logic ready; logic [7:0] pend;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffered results, bypass count of the head, pending set.
  ent_t       m_q[$];
  int         m_age = 0;
  logic [7:0] m_pend = '0;
  exp_t       exp_q[$];
  logic [2:0] outs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_age  = 0;
    m_pend = '0;
  endtask

  // Drive one cycle of inputs, predict the outputs, then advance the model.
  task automatic set_in(input logic pv, input logic [2:0] pr, input logic [15:0] pd,
                        input logic iv, input logic [2:0] ir,
                        input logic lv, input logic [2:0] lr, input logic [15:0] ld);
    exp_t e;
    int   cnt;
    logic fg;
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    issue_valid = iv; issue_reg = ir;
    lu_valid = lv; lu_reg = lr; lu_data = ld;
    cnt = m_q.size();
    fg  = (cnt > 0) && (!pv || cnt == 2 || m_age >= AGE_MAX);
    e.en    = fg || pv;
    e.r     = fg ? m_q[0].r : (pv ? pr : 3'd0);
    e.d     = fg ? m_q[0].d : (pv ? pd : 16'd0);
    e.stall = pv && fg;
    e.ready = (cnt < 2);
    e.pend  = m_pend;
    exp_q.push_back(e);
    if (cnt == 0 || fg) m_age = 0;
    else if (m_age < AGE_MAX) m_age++;
    if (fg) begin
      m_pend[m_q[0].r] = 1'b0;
      void'(m_q.pop_front());
    end
    if (lv && cnt < 2) m_q.push_back('{r: lr, d: ld});
    if (iv) m_pend[ir] = 1'b1;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      if (rst_n && rf_wr_en) check("unexpected_write", 32'(rf_wr_en), 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (rst_n) begin
        check("rf_wr_en", 32'(rf_wr_en), 32'(e.en));
        if (e.en) begin
          check("rf_wr_reg", 32'(rf_wr_reg), 32'(e.r));
          check("rf_wr_data", 32'(rf_wr_data), 32'(e.d));
        end
        check("pipe_stall", 32'(pipe_stall), 32'(e.stall));
        check("lu_ready", 32'(lu_ready), 32'(e.ready));
        check("pend_busy", 32'(pend_busy), 32'(e.pend));
      end
    end
  end

  // Protocol rules the hazard unit guarantees; the stimulus must respect them.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(issue_valid && pend_busy[issue_reg] && !(rf_wr_en && rf_wr_reg == issue_reg)))
        else $error("protocol: issue to pending register %0d", issue_reg);
      assert (!(pipe_valid && pend_busy[pipe_reg]))
        else $error("protocol: pipeline write to pending register %0d", pipe_reg);
      assert (!(lu_valid && !pend_busy[lu_reg]))
        else $error("protocol: result for non-pending register %0d", lu_reg);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] fr[$];
    logic       pv, iv, lv;
    logic [2:0] pr, ir, lr;
    int         idx;

    // Reset state
    #12;
    check("rst_lu_ready", 32'(lu_ready), 32'd1);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_pend", 32'(pend_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pipeline only
    set_in(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    #1;
    check("pipe_en", 32'(rf_wr_en), 32'd1);
    check("pipe_reg", 32'(rf_wr_reg), 32'd3);
    check("pipe_data", 32'(rf_wr_data), 32'hBEEF);
    check("pipe_stall0", 32'(pipe_stall), 32'd0);
    check("pipe_pend", 32'(pend_busy), 32'd0);
    tick();

    // Long op with idle pipeline
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 1'b0, 3'd0, 16'd0); tick();
    check("lop_pend_set", 32'(pend_busy), 32'h20);
    repeat (3) begin idle(); tick(); end
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1, 3'd5, 16'h1234);
    #1;
    check("lop_no_bypass", 32'(rf_wr_en), 32'd0);
    tick();
    idle(); #1;
    check("lop_wr_en", 32'(rf_wr_en), 32'd1);
    check("lop_wr_reg", 32'(rf_wr_reg), 32'd5);
    check("lop_wr_data", 32'(rf_wr_data), 32'h1234);
    check("lop_pend_hold", 32'(pend_busy), 32'h20);
    tick();
    check("lop_pend_clr", 32'(pend_busy), 32'h00);

    // Aging: one buffered entry under a continuous pipeline stream
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 1'b1, 3'd6, 16'h6666); tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 3'd1, 16'(k), 1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
      #1;
      check("age_stall", 32'(pipe_stall), (k == AGE_MAX) ? 32'd1 : 32'd0);
      check("age_reg", 32'(rf_wr_reg), (k == AGE_MAX) ? 32'd6 : 32'd1);
      tick();
    end

    // Full FIFO while the pipeline is held
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b1, 3'd1, 16'h0101, 1'b0, 3'd0, 1'b1, 3'd4, 16'hA4A4); tick();
    set_in(1'b1, 3'd1, 16'h0202, 1'b0, 3'd0, 1'b1, 3'd7, 16'hA7A7);
    #1;
    check("full_stall_pre", 32'(pipe_stall), 32'd0);
    tick();
    set_in(1'b1, 3'd1, 16'h0303, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    #1;
    check("full_ready", 32'(lu_ready), 32'd0);
    check("full_stall", 32'(pipe_stall), 32'd1);
    check("full_reg", 32'(rf_wr_reg), 32'd4);
    check("full_data", 32'(rf_wr_data), 32'hA4A4);
    tick();
    set_in(1'b1, 3'd1, 16'h0404, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    #1;
    check("full_ready_back", 32'(lu_ready), 32'd1);
    check("full_stall_back", 32'(pipe_stall), 32'd0);
    tick();
    repeat (2) begin idle(); tick(); end
    check("full_pend_clr", 32'(pend_busy), 32'd0);

    // Set wins over clear on the same register
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1, 3'd2, 16'h2222); tick();
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'd0);
    #1;
    check("sim_wr_reg", 32'(rf_wr_reg), 32'd2);
    tick();
    check("sim_pend_kept", 32'(pend_busy), 32'h04);
    set_in(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1, 3'd2, 16'h2323); tick();
    repeat (2) begin idle(); tick(); end
    check("sim_pend_clr", 32'(pend_busy), 32'd0);

    // Reset with a full FIFO and two pending registers
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'd0); tick();
    set_in(1'b1, 3'd1, 16'h0505, 1'b0, 3'd0, 1'b1, 3'd2, 16'hC2C2); tick();
    set_in(1'b1, 3'd1, 16'h0606, 1'b0, 3'd0, 1'b1, 3'd3, 16'hC3C3); tick();
    check("mid_full", 32'(lu_ready), 32'd0);
    check("mid_pend", 32'(pend_busy), 32'h0C);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_ready", 32'(lu_ready), 32'd1);
    check("mid_rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("mid_rst_pend", 32'(pend_busy), 32'd0);
    tick();
    idle(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(); #1;
      check("post_rst_no_write", 32'(rf_wr_en), 32'd0);
      tick();
    end

    // Randomized legal traffic
    for (int c = 0; c < 2000; c++) begin
      fr.delete();
      for (int r = 0; r < 8; r++) if (!m_pend[r]) fr.push_back(3'(r));
      pv = ($urandom_range(0, 3) != 0) && (fr.size() > 0);
      pr = (fr.size() > 0) ? fr[$urandom_range(0, fr.size() - 1)] : 3'd0;
      iv = ($urandom_range(0, 2) == 0) && (fr.size() > 0);
      ir = (fr.size() > 0) ? fr[$urandom_range(0, fr.size() - 1)] : 3'd0;
      lv = (outs.size() > 0) && ($urandom_range(0, 1) == 1);
      lr = 3'd0;
      if (lv) begin
        idx = $urandom_range(0, outs.size() - 1);
        lr  = outs[idx];
        if (m_q.size() < 2) outs.delete(idx);
      end
      set_in(pv, pr, 16'($urandom), iv, ir, lv, lr, 16'($urandom));
      if (iv) outs.push_back(ir);
      tick();
    end
    repeat (8) begin idle(); tick(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
